// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared types and constants for the instruction-memory loader.
//   loader_state_e     : FSM state encoding of the loader
//   SYNC_BYTE_DEFAULT  : default frame start marker
//   word_byte_addr()   : word index -> byte address (word aligned)
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        LEN0,
        LEN1,
        DATA,
        CSUM,
        FIN,
        ERR
    } loader_state_e;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    function automatic logic [17:0] word_byte_addr(input logic [15:0] idx);
        return {idx, 2'b00};
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Bus interfaces used by the instruction-memory loader.
//   byte_stream_if : valid/ready byte stream
//       master drives rx_data, rx_valid; slave drives rx_ready
//   imem_wr_if     : imem write port (no back-pressure)
//       master drives mem_we, mem_addr, mem_wdata
interface byte_stream_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (output rx_data, output rx_valid, input rx_ready);
    modport slave  (input rx_data, input rx_valid, output rx_ready);
endinterface

interface imem_wr_if #(
    parameter int ADDR_W = 12
);
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (output mem_we, output mem_addr, output mem_wdata);
    modport slave  (input mem_we, input mem_addr, input mem_wdata);
endinterface

// File: rtl/imem_loader_word_pack.sv
// loader_word_pack
//   Packs accepted bytes little-endian into 32-bit words.
//   clk, reset  : clock, synchronous active-high reset
//   clear       : restart at lane 0, drop any partial word
//   byte_valid  : byte_data is consumed this cycle
//   byte_data   : incoming byte
//   last_lane   : the next consumed byte completes a word
//   word_valid  : one-cycle pulse, the cycle after the completing byte
//   word        : assembled word; holds its value between pulses
module loader_word_pack (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  lane_q;
    logic [23:0] asm_q;

    assign last_lane = (lane_q == 2'd3);

    always_ff @(posedge clk) begin
        if (reset) begin
            lane_q     <= 2'd0;
            asm_q      <= 24'd0;
            word_valid <= 1'b0;
            word       <= 32'd0;
        end else begin
            word_valid <= 1'b0;
            if (clear) begin
                lane_q <= 2'd0;
                asm_q  <= 24'd0;
            end else if (byte_valid) begin
                lane_q <= lane_q + 2'd1;
                case (lane_q)
                    2'd0: asm_q[7:0]   <= byte_data;
                    2'd1: asm_q[15:8]  <= byte_data;
                    2'd2: asm_q[23:16] <= byte_data;
                    default: begin
                        word_valid <= 1'b1;
                        word       <= {byte_data, asm_q};
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Runtime program loader: parses a framed byte stream (SYNC, LEN lo,
//   LEN hi, LEN*4 payload bytes, optional checksum byte) and writes the
//   payload as 32-bit words to imem from byte address 0. Keeps the core
//   in reset while a load is running.
//   clk, reset       : clock, synchronous active-high reset
//   start            : begin a load (ignored while busy)
//   rx               : byte stream slave (rx_data, rx_valid, rx_ready)
//   mem              : imem write master (mem_we, mem_addr, mem_wdata)
//   busy / core_hold : load in progress
//   done / err       : sticky result of the last load
//   Build option IMEM_LOADER_CSUM_EN: expect a trailing byte equal to the
//   mod-256 sum of the payload; mismatch ends the load with err.
//
//   state | meaning
//   IDLE  | waiting for start
//   SYNC  | discarding bytes until the sync marker
//   LEN0  | expecting word count, low byte
//   LEN1  | expecting word count, high byte; range check
//   DATA  | collecting payload, one imem write per 4 bytes
//   CSUM  | expecting checksum byte (checksum builds only)
//   FIN   | load ok: set done, drop busy
//   ERR   | load aborted: set err, drop busy
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int         ADDR_W      = 12,
    parameter int         DEPTH_WORDS = 128,
    parameter logic [7:0] SYNC_BYTE   = SYNC_BYTE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    byte_stream_if.slave   rx,
    imem_wr_if.master      mem,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           core_hold
);

    loader_state_e     state_q, state_d;
    logic [15:0]       len_q;
    logic [15:0]       word_idx_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q, done_q, err_q;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    logic              accept;
    logic              last_lane;
    logic              last_word;
    logic [15:0]       len_full;

    // rx_ready depends only on the state register, never on rx_valid
    assign rx.rx_ready = (state_q == SYNC) || (state_q == LEN0) || (state_q == LEN1) ||
                         (state_q == DATA) || (state_q == CSUM);
    assign accept    = rx.rx_valid && rx.rx_ready;
    assign len_full  = {rx.rx_data, len_q[7:0]};
    assign last_word = (word_idx_q == len_q - 16'd1);

    loader_word_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .clear      (state_q == IDLE),
        .byte_valid (accept && (state_q == DATA)),
        .byte_data  (rx.rx_data),
        .last_lane  (last_lane),
        .word_valid (mem.mem_we),
        .word       (mem.mem_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = SYNC;
            SYNC: if (accept && (rx.rx_data == SYNC_BYTE)) state_d = LEN0;
            LEN0: if (accept) state_d = LEN1;
            LEN1: begin
                if (accept) begin
                    if (len_full == 16'd0)                    state_d = FIN;
                    else if (len_full > 16'(DEPTH_WORDS))     state_d = ERR;
                    else                                      state_d = DATA;
                end
            end
            DATA: begin
                if (accept && last_lane && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
                    state_d = CSUM;
`else
                    state_d = FIN;
`endif
                end
            end
`ifdef IMEM_LOADER_CSUM_EN
            CSUM: if (accept) state_d = (rx.rx_data == csum_q) ? FIN : ERR;
`endif
            FIN:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            len_q      <= 16'd0;
            word_idx_q <= 16'd0;
            addr_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        len_q      <= 16'd0;
                        word_idx_q <= 16'd0;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q     <= 8'd0;
`endif
                    end
                end
                LEN0: if (accept) len_q[7:0]  <= rx.rx_data;
                LEN1: if (accept) len_q[15:8] <= rx.rx_data;
                DATA: begin
                    if (accept) begin
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q <= csum_q + rx.rx_data;
`endif
                        // address is registered alongside the packed word so
                        // both appear together on the write cycle
                        if (last_lane) begin
                            addr_q     <= ADDR_W'(word_byte_addr(word_idx_q));
                            word_idx_q <= word_idx_q + 16'd1;
                        end
                    end
                end
                FIN: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                ERR: begin
                    busy_q <= 1'b0;
                    err_q  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign mem.mem_addr = addr_q;
    assign busy         = busy_q;
    assign core_hold    = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader: table of fixed frames, a frame-level
//   reference model for randomized frames, and hand sequences for reset,
//   start-while-busy and (with IMEM_LOADER_CSUM_EN) checksum handling.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int         ADDR_W = 12;
    localparam int         DEPTH  = 128;
    localparam logic [7:0] SYNC   = SYNC_BYTE_DEFAULT;

    typedef struct packed {
        logic [127:0] b;     // frame bytes, first byte in the top octet
        logic [7:0]   n;
        logic [7:0]   nw;
        logic [31:0]  w0;
        logic [31:0]  w1;
        logic         d;
        logic         e;
    } vec_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic busy, done, err, core_hold;

    byte_stream_if                  rx_bus ();
    imem_wr_if #(.ADDR_W(ADDR_W))   mem_bus ();

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .SYNC_BYTE(SYNC)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rx        (rx_bus),
        .mem       (mem_bus),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .core_hold (core_hold)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]        tx[$];
    logic [7:0]        full[$];
    logic [31:0]       got_data[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       exp_data[$];
    bit                exp_done, exp_err, has_payload;
    logic [7:0]        exp_sum;

    always @(negedge clk) begin
        if (mem_bus.mem_we === 1'b1) begin
            got_addr.push_back(mem_bus.mem_addr);
            got_data.push_back(mem_bus.mem_wdata);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Frame-level reference: find marker, read count, cut payload into words.
    task automatic model_run();
        int i, n, len, p;
        logic [31:0] w;
        exp_data.delete();
        exp_done = 0; exp_err = 0; exp_sum = 8'd0; has_payload = 0;
        n = tx.size();
        i = 0;
        while (i < n && tx[i] != SYNC) i++;
        if (i + 2 >= n) return;
        len = int'(tx[i+1]) + 256 * int'(tx[i+2]);
        p = i + 3;
        if (len == 0) begin exp_done = 1; return; end
        if (len > DEPTH) begin exp_err = 1; return; end
        has_payload = 1;
        for (int k = 0; k < len; k++) begin
            w = 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (p < n) begin
                    w = w | (32'(tx[p]) << (8 * b));
                    exp_sum = exp_sum + tx[p];
                end
                p++;
            end
            exp_data.push_back(w);
        end
`ifdef IMEM_LOADER_CSUM_EN
        if (p < n) begin
            exp_done = (tx[p] == exp_sum);
            exp_err  = (tx[p] != exp_sum);
        end
`else
        exp_done = 1;
`endif
    endtask

    task automatic seal_frame();
        model_run();
`ifdef IMEM_LOADER_CSUM_EN
        if (has_payload) begin
            tx.push_back(exp_sum);
            model_run();
        end
`endif
    endtask

    task automatic send(input bit rv);
        int   idx, cyc;
        logic acc;
        idx = 0; cyc = 0;
        while (idx < tx.size() && cyc < 4000) begin
            @(negedge clk);
            rx_bus.rx_valid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
            rx_bus.rx_data  = tx[idx];
            acc = rx_bus.rx_valid && rx_bus.rx_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        rx_bus.rx_valid = 1'b0;
        check("bytes_accepted", idx, tx.size());
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_after_start", busy, 1);
        check("hold_after_start", core_hold, 1);
    endtask

    task automatic wait_idle();
        int c;
        c = 0;
        while (busy && c < 50) begin
            @(negedge clk);
            c++;
        end
        check("busy_falls", busy, 0);
    endtask

    task automatic run_frame(input bit rv);
        got_data.delete();
        got_addr.delete();
        pulse_start();
        send(rv);
        wait_idle();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  busy, 0);
        check({tag, "_done"},  done, 0);
        check({tag, "_err"},   err, 0);
        check({tag, "_hold"},  core_hold, 0);
        check({tag, "_ready"}, rx_bus.rx_ready, 0);
        check({tag, "_we"},    mem_bus.mem_we, 0);
        check({tag, "_addr"},  mem_bus.mem_addr, 0);
        check({tag, "_wdata"}, mem_bus.mem_wdata, 0);
    endtask

    initial begin
        vec_t vecs[4];
        vec_t v;
        int   len;

        vecs[0] = '{b: {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20, 40'h0},
                    n: 8'd11, nw: 8'd2, w0: 32'h00000013, w1: 32'h200005B7, d: 1'b1, e: 1'b0};
        vecs[1] = '{b: {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h6F, 8'hF0, 8'h9F, 8'hFF, 56'h0},
                    n: 8'd9, nw: 8'd1, w0: 32'hFF9FF06F, w1: 32'h0, d: 1'b1, e: 1'b0};
        vecs[2] = '{b: {8'hA5, 8'h81, 8'h00, 104'h0},
                    n: 8'd3, nw: 8'd0, w0: 32'h0, w1: 32'h0, d: 1'b0, e: 1'b1};
        vecs[3] = '{b: {8'hA5, 8'h00, 8'h00, 104'h0},
                    n: 8'd3, nw: 8'd0, w0: 32'h0, w1: 32'h0, d: 1'b1, e: 1'b0};

        rx_bus.rx_valid = 1'b0;
        rx_bus.rx_data  = 8'd0;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // fixed frames
        for (int k = 0; k < 4; k++) begin
            v = vecs[k];
            tx.delete();
            for (int i = 0; i < int'(v.n); i++) tx.push_back(v.b[127 - 8*i -: 8]);
            seal_frame();
            run_frame(k == 1);
            check("vec_nwrites", got_data.size(), v.nw);
            if (v.nw >= 1 && got_data.size() >= 1) begin
                check("vec_addr0", got_addr[0], 0);
                check("vec_data0", got_data[0], v.w0);
            end
            if (v.nw >= 2 && got_data.size() >= 2) begin
                check("vec_addr1", got_addr[1], 4);
                check("vec_data1", got_data[1], v.w1);
            end
            check("vec_done", done, v.d);
            check("vec_err", err, v.e);
            check("vec_hold", core_hold, 0);
            check("vec_ready", rx_bus.rx_ready, 0);
            if (v.nw >= 1) begin
                check("addr_holds", mem_bus.mem_addr, (int'(v.nw) - 1) * 4);
                check("wdata_holds", mem_bus.mem_wdata, (v.nw == 8'd1) ? v.w0 : v.w1);
            end
        end

        // randomized frames against the reference model
        for (int it = 0; it < 3; it++) begin
            len = (it == 0) ? DEPTH : int'($urandom_range(1, DEPTH));
            tx.delete();
            repeat ($urandom_range(0, 3)) tx.push_back(8'($urandom_range(0, 8'hA4)));
            tx.push_back(SYNC);
            tx.push_back(len[7:0]);
            tx.push_back(len[15:8]);
            repeat (4 * len) tx.push_back(8'($urandom));
            seal_frame();
            run_frame(1);
            check("rnd_nwrites", got_data.size(), exp_data.size());
            for (int w = 0; w < exp_data.size() && w < got_data.size(); w++) begin
                check("rnd_addr", got_addr[w], w * 4);
                check("rnd_data", got_data[w], exp_data[w]);
            end
            check("rnd_done", done, exp_done);
            check("rnd_err", err, exp_err);
        end

        // reset in the middle of word 1
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05};
        got_data.delete();
        got_addr.delete();
        pulse_start();
        send(0);
        @(negedge clk) reset = 1'b1;
        @(negedge clk);
        check_all_zero("midrst");
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("midrst_nwrites", got_data.size(), 1);

        // clean reload after the aborted one
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
        seal_frame();
        run_frame(0);
        check("reload_nwrites", got_data.size(), 2);
        if (got_data.size() == 2) check("reload_data1", got_data[1], 32'h200005B7);
        check("reload_done", done, 1);

        // start while busy is ignored
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20};
        seal_frame();
        full = tx;
        got_data.delete();
        got_addr.delete();
        pulse_start();
        tx = full[0:4];
        send(0);
        pulse_start();
        tx = full[5:$];
        send(0);
        wait_idle();
        check("busy_start_nwrites", got_data.size(), 2);
        if (got_data.size() == 2) check("busy_start_data1", got_data[1], 32'h200005B7);
        check("busy_start_done", done, 1);

        // start and reset together: reset wins
        @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rst_start_busy", busy, 0);
        check("rst_start_ready", rx_bus.rx_ready, 0);
        check("rst_start_done", done, 0);

`ifdef IMEM_LOADER_CSUM_EN
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20, 8'hEF};
        run_frame(0);
        check("csum_ok_done", done, 1);
        check("csum_ok_err", err, 0);
        tx = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hB7, 8'h05, 8'h00, 8'h20, 8'h00};
        run_frame(0);
        check("csum_bad_err", err, 1);
        check("csum_bad_done", done, 0);
        check("csum_bad_nwrites", got_data.size(), 2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
